// File: rtl/intra_mode_decision.sv
// rtl/intra_mode_decision.sv - luma intra mode decision (Vertical/Horizontal/DC SAD, row-serial)
// Captures one macroblock plus neighbours, accumulates one row per cycle, picks the cheapest mode.
module intra_mode_decision #(
  parameter int MB_SIZE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  mb [MB_SIZE*MB_SIZE],
  input  logic [7:0]  toppixels [MB_SIZE],
  input  logic [7:0]  leftpixels [MB_SIZE],
  output logic        busy,
  output logic        done,
  output logic [1:0]  best_mode,
  output logic [15:0] best_sad,
  output logic [15:0] sad_v,
  output logic [15:0] sad_h,
  output logic [15:0] sad_dc,
  output logic [7:0]  dc_value
);

  localparam int ROW_W = $clog2(MB_SIZE);
  localparam int SUM_W = 8 + $clog2(2 * MB_SIZE);

  typedef enum logic [2:0] {IDLE, DCSUM, ROWS, DECIDE, DONE} state_t;

  state_t state, next_state;

  logic [ROW_W-1:0] row;
  logic [7:0]       mb_q   [MB_SIZE*MB_SIZE];
  logic [7:0]       top_q  [MB_SIZE];
  logic [7:0]       left_q [MB_SIZE];

  logic [SUM_W-1:0] dc_sum;
  logic [SUM_W-1:0] dc_round;
  logic [7:0]       cur_row [MB_SIZE];
  logic [7:0]       cur_left;
  logic [15:0]      row_v, row_h, row_dc;
  logic [1:0]       dec_mode;
  logic [15:0]      dec_sad;

  function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[8] ? 8'(-d) : d[7:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = DCSUM;
      end
      DCSUM: begin
        busy       = 1'b1;
        next_state = ROWS;
      end
      ROWS: begin
        busy = 1'b1;
        if (row == ROW_W'(MB_SIZE - 1)) next_state = DECIDE;
      end
      DECIDE: begin
        busy       = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Full-width neighbour sum; adding MB_SIZE before the shift gives round-half-up.
  always_comb begin
    dc_sum = '0;
    for (int k = 0; k < MB_SIZE; k++) begin
      dc_sum = dc_sum + SUM_W'(top_q[k]) + SUM_W'(left_q[k]);
    end
  end

  assign dc_round = dc_sum + SUM_W'(MB_SIZE);

  always_comb begin
    cur_left = '0;
    for (int k = 0; k < MB_SIZE; k++) cur_row[k] = '0;
    for (int r = 0; r < MB_SIZE; r++) begin
      if (row == ROW_W'(r)) begin
        cur_left = left_q[r];
        for (int k = 0; k < MB_SIZE; k++) cur_row[k] = mb_q[r*MB_SIZE+k];
      end
    end
  end

  always_comb begin
    row_v  = '0;
    row_h  = '0;
    row_dc = '0;
    for (int k = 0; k < MB_SIZE; k++) begin
      row_v  = row_v  + 16'(absdiff(cur_row[k], top_q[k]));
      row_h  = row_h  + 16'(absdiff(cur_row[k], cur_left));
      row_dc = row_dc + 16'(absdiff(cur_row[k], dc_value));
    end
  end

  // Strict compares in V, H, DC order so ties keep the earlier mode.
  always_comb begin
    dec_mode = 2'd0;
    dec_sad  = sad_v;
    if (sad_h < dec_sad) begin
      dec_mode = 2'd1;
      dec_sad  = sad_h;
    end
    if (sad_dc < dec_sad) begin
      dec_mode = 2'd2;
      dec_sad  = sad_dc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row       <= '0;
      mb_q      <= '{default: 8'd0};
      top_q     <= '{default: 8'd0};
      left_q    <= '{default: 8'd0};
      sad_v     <= '0;
      sad_h     <= '0;
      sad_dc    <= '0;
      dc_value  <= '0;
      best_mode <= '0;
      best_sad  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mb_q   <= mb;
            top_q  <= toppixels;
            left_q <= leftpixels;
            sad_v  <= '0;
            sad_h  <= '0;
            sad_dc <= '0;
            row    <= '0;
          end
        end
        DCSUM: begin
          dc_value <= 8'(dc_round >> (SUM_W - 8));
        end
        ROWS: begin
          sad_v  <= sad_v + row_v;
          sad_h  <= sad_h + row_h;
          sad_dc <= sad_dc + row_dc;
          row    <= row + ROW_W'(1);
        end
        DECIDE: begin
          best_mode <= dec_mode;
          best_sad  <= dec_sad;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_intra_mode_decision.sv
// tb/tb_intra_mode_decision.sv - directed bench for intra_mode_decision (MB_SIZE = 16)
module tb_intra_mode_decision;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  mb [N*N];
  logic [7:0]  top [N];
  logic [7:0]  left [N];
  logic        busy, done;
  logic [1:0]  best_mode;
  logic [15:0] best_sad, sad_v, sad_h, sad_dc;
  logic [7:0]  dc_value;

  int checks = 0;
  int errors = 0;

  intra_mode_decision #(.MB_SIZE(N)) dut (
    .clk(clk), .reset(reset), .start(start),
    .mb(mb), .toppixels(top), .leftpixels(left),
    .busy(busy), .done(done), .best_mode(best_mode), .best_sad(best_sad),
    .sad_v(sad_v), .sad_h(sad_h), .sad_dc(sad_dc), .dc_value(dc_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int m, input int t, input int l);
    for (int i = 0; i < N*N; i++) mb[i] = 8'(m);
    for (int k = 0; k < N; k++) begin
      top[k]  = 8'(t);
      left[k] = 8'(l);
    end
  endtask

  task automatic fill_horiz();
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < N; k++) mb[r*N+k] = 8'(10*r);
      left[r] = 8'(10*r);
      top[r]  = 8'd0;
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge E0.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_res(input string tag, input int dcv, input int sv, input int sh,
                           input int sdc, input int bm, input int bs);
    check({tag, ".done"}, done, 1);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".dc_value"}, dc_value, dcv);
    check({tag, ".sad_v"}, sad_v, sv);
    check({tag, ".sad_h"}, sad_h, sh);
    check({tag, ".sad_dc"}, sad_dc, sdc);
    check({tag, ".best_mode"}, best_mode, bm);
    check({tag, ".best_sad"}, best_sad, bs);
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
  endtask

  initial begin
    int n;
    int cnt;
    reset = 1'b1;
    start = 1'b0;
    fill(0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.best_mode", best_mode, 0);
    check("rst.best_sad", best_sad, 0);
    check("rst.sad_v", sad_v, 0);
    check("rst.dc_value", dc_value, 0);
    reset = 1'b0;
    @(negedge clk);

    // Vertical wins, with latency check
    fill(100, 100, 50);
    pulse_start();
    check("v.busy_after_e0", busy, 1);
    wait_done(n);
    check("v.latency", n, 18);
    check_res("v", 75, 0, 12800, 6400, 0, 0);
    @(negedge clk);
    check("v.done_one_cycle", done, 0);

    // Horizontal wins
    fill_horiz();
    pulse_start();
    wait_done(n);
    check("h.latency", n, 18);
    check_res("h", 38, 19200, 0, 12416, 1, 0);
    @(negedge clk);

    // DC wins; start held through DONE is ignored there, then accepted back-to-back
    fill(60, 40, 80);
    pulse_start();
    wait_done(n);
    check_res("dc", 60, 5120, 5120, 0, 2, 0);
    fill(128, 128, 128);
    start = 1'b1;
    @(negedge clk);
    check("b2b.start_in_done_ignored", busy, 0);
    @(negedge clk);
    start = 1'b0;
    check("b2b.accepted", busy, 1);
    wait_done(n);
    check("b2b.latency", n, 18);
    check_res("tie128", 128, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Saturation bound
    fill(255, 0, 0);
    pulse_start();
    wait_done(n);
    check_res("sat", 0, 65280, 65280, 65280, 0, 65280);
    @(negedge clk);

    // Inputs changed and start pulsed while busy
    fill(100, 100, 50);
    pulse_start();
    repeat (3) @(negedge clk);
    fill(60, 40, 80);
    pulse_start();
    wait_done(n);
    check("busy_start.latency", n, 14);
    check_res("busy_start", 75, 0, 12800, 6400, 0, 0);
    count_done(25, cnt);
    check("busy_start.single_done", cnt, 0);

    // Reset mid-block
    fill(100, 100, 50);
    pulse_start();
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst.busy", busy, 0);
    check("midrst.done", done, 0);
    check("midrst.sad_h", sad_h, 0);
    check("midrst.dc_value", dc_value, 0);
    check("midrst.best_sad", best_sad, 0);
    @(negedge clk);
    reset = 1'b0;
    count_done(30, cnt);
    check("midrst.no_done", cnt, 0);
    fill(60, 40, 80);
    pulse_start();
    wait_done(n);
    check("post_rst.latency", n, 18);
    check_res("post_rst", 60, 5120, 5120, 0, 2, 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
